// File: rtl/spi_sclk_gen_if.sv
// spi_sclk_gen_if: burst request in, SCLK pin, bit strobes and status out.
// Ports: clk_cnt_en, sclk, shift_en, sample_en, busy, edge_cnt[CNT_W].
interface spi_sclk_gen_if #(
    parameter int CNT_W = 16
);
    logic             clk_cnt_en;
    logic             sclk;
    logic             shift_en;
    logic             sample_en;
    logic             busy;
    logic [CNT_W-1:0] edge_cnt;

    modport master (
        input  clk_cnt_en,
        output sclk,
        output shift_en,
        output sample_en,
        output busy,
        output edge_cnt
    );

    modport slave (
        output clk_cnt_en,
        input  sclk,
        input  shift_en,
        input  sample_en,
        input  busy,
        input  edge_cnt
    );
endinterface

// File: rtl/spi_sclk_gen.sv
// spi_sclk_gen: SPI serial clock and shift/sample strobe generator with CS gaps.
// Ports: clk, rst (sync, active-high), bus (master modport of spi_sclk_gen_if).
module spi_sclk_gen #(
    parameter int CLK_DIV   = 4,
    parameter bit CPOL      = 1'b0,
    parameter bit CPHA      = 1'b0,
    parameter int SETUP_CYC = 2,
    parameter int HOLD_CYC  = 2,
    parameter int CNT_W     = 16
) (
    input logic            clk,
    input logic            rst,
    spi_sclk_gen_if.master bus
);
    localparam int DW = $clog2(CLK_DIV);
    localparam int SW = $clog2(SETUP_CYC + 1);
    localparam int HW = $clog2(HOLD_CYC + 1);

    localparam logic [DW-1:0] DIV_LAST  = DW'(CLK_DIV - 1);
    localparam logic [SW-1:0] SET_LAST  = SW'(SETUP_CYC - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYC - 1);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        RUN,
        DRAIN,
        HOLD
    } state_t;

    state_t           state_q, state_d;
    logic [DW-1:0]    div_q, div_d;
    logic [SW-1:0]    set_q, set_d;
    logic [HW-1:0]    hold_q, hold_d;
    logic             sclk_q, sclk_d;
    logic             shift_q, shift_d;
    logic             sample_q, sample_d;
    logic             busy_q, busy_d;
    logic [CNT_W-1:0] edge_q, edge_d;

    logic wrap;
    logic at_idle;

    assign wrap    = (div_q == DIV_LAST);
    // sclk at its idle level means the next toggle is a leading edge
    assign at_idle = (sclk_q == CPOL);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            div_q    <= '0;
            set_q    <= '0;
            hold_q   <= '0;
            sclk_q   <= CPOL;
            shift_q  <= 1'b0;
            sample_q <= 1'b0;
            busy_q   <= 1'b0;
            edge_q   <= '0;
        end else begin
            state_q  <= state_d;
            div_q    <= div_d;
            set_q    <= set_d;
            hold_q   <= hold_d;
            sclk_q   <= sclk_d;
            shift_q  <= shift_d;
            sample_q <= sample_d;
            busy_q   <= busy_d;
            edge_q   <= edge_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        div_d    = div_q;
        set_d    = set_q;
        hold_d   = hold_q;
        sclk_d   = sclk_q;
        shift_d  = 1'b0;
        sample_d = 1'b0;
        edge_d   = edge_q;
        unique case (state_q)
            IDLE: begin
                sclk_d = CPOL;
                if (bus.clk_cnt_en) begin
                    state_d = SETUP;
                    set_d   = '0;
                    edge_d  = '0;
                end
            end
            SETUP: begin
                if (!bus.clk_cnt_en) begin
                    state_d = HOLD;
                    hold_d  = '0;
                end else if (set_q == SET_LAST) begin
                    state_d = RUN;
                    div_d   = '0;
                end else begin
                    set_d = set_q + 1'b1;
                end
            end
            RUN: begin
                if (!bus.clk_cnt_en) begin
                    if (at_idle) begin
                        state_d = HOLD;
                        hold_d  = '0;
                    end else if (wrap) begin
                        // trailing edge falls on this very clock: no drain needed
                        sclk_d  = CPOL;
                        div_d   = '0;
                        state_d = HOLD;
                        hold_d  = '0;
                    end else begin
                        div_d   = div_q + 1'b1;
                        state_d = DRAIN;
                    end
                end else if (wrap) begin
                    div_d  = '0;
                    sclk_d = ~sclk_q;
                    if (at_idle) begin
                        if (edge_q != '1) begin
                            edge_d = edge_q + 1'b1;
                        end
                        sample_d = !CPHA;
                        shift_d  = CPHA;
                    end else begin
                        sample_d = CPHA;
                        shift_d  = !CPHA;
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            DRAIN: begin
                // close the open half-period silently
                if (wrap) begin
                    sclk_d  = CPOL;
                    div_d   = '0;
                    state_d = HOLD;
                    hold_d  = '0;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            HOLD: begin
                sclk_d = CPOL;
                if (hold_q == HOLD_LAST) begin
                    state_d = IDLE;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                sclk_d  = CPOL;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    assign bus.sclk      = sclk_q;
    assign bus.shift_en  = shift_q;
    assign bus.sample_en = sample_q;
    assign bus.busy      = busy_q;
    assign bus.edge_cnt  = edge_q;
endmodule

// File: tb/tb_spi_sclk_gen.sv
// tb_spi_sclk_gen: directed scoreboard bench for two generator configurations.
// Ports: none (top-level bench).
module tb_spi_sclk_gen;
    logic clk;
    logic rst;
    logic load;
    logic [7:0] sr;

    int vectors;
    int miscompares;

    typedef struct packed {
        logic        sclk;
        logic        shift;
        logic        sample;
        logic        busy;
        logic [15:0] ecnt;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    logic bitq[$];

    spi_sclk_gen_if #(.CNT_W(16)) if0 ();
    spi_sclk_gen_if #(.CNT_W(16)) if1 ();

    spi_sclk_gen #(
        .CLK_DIV(4), .CPOL(1'b0), .CPHA(1'b0),
        .SETUP_CYC(2), .HOLD_CYC(2), .CNT_W(16)
    ) dut0 (
        .clk(clk),
        .rst(rst),
        .bus(if0.master)
    );

    spi_sclk_gen #(
        .CLK_DIV(4), .CPOL(1'b1), .CPHA(1'b1),
        .SETUP_CYC(2), .HOLD_CYC(2), .CNT_W(16)
    ) dut1 (
        .clk(clk),
        .rst(rst),
        .bus(if1.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // MOSI shifter model: MSB first, shifts after each shift_en cycle
    always @(posedge clk) begin
        if (load) begin
            sr <= 8'hA5;
        end else if (if0.shift_en) begin
            sr <= {sr[6:0], 1'b0};
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t idle_exp(input bit cpol);
        exp_t e;
        e = '0;
        e.sclk = cpol;
        return e;
    endfunction

    // en held from T0: edges at T7 + 4k, first edge leading
    function automatic exp_t run_exp(input int n, input bit cpol,
                                     input bit cpha);
        exp_t e;
        int m;
        logic lead;
        logic trail;
        e = idle_exp(cpol);
        e.busy = (n >= 1);
        if (n >= 7) begin
            m = n - 7;
            e.sclk = cpol ^ ((m / 4) % 2 == 0);
            lead = (m % 8 == 0);
            trail = (m % 8 == 4);
            e.sample = cpha ? trail : lead;
            e.shift = cpha ? lead : trail;
            e.ecnt = 16'(m / 8 + 1);
        end
        return e;
    endfunction

    // en dropped during T8: silent trailing edge at T11, IDLE at T13
    function automatic exp_t drop_exp(input int n, input bit cpol,
                                      input bit cpha);
        exp_t e;
        if (n <= 8) return run_exp(n, cpol, cpha);
        e = idle_exp(cpol);
        e.sclk = (n <= 10) ? !cpol : cpol;
        e.busy = (n <= 12);
        e.ecnt = 16'd1;
        return e;
    endfunction

    // one-cycle request at T0: SETUP aborts, IDLE again at T4
    function automatic exp_t pulse_exp(input int n, input bit cpol);
        exp_t e;
        e = idle_exp(cpol);
        e.busy = (n <= 3);
        return e;
    endfunction

    function automatic exp_t get_obs(input int d);
        exp_t o;
        if (d == 0) begin
            o.sclk = if0.sclk;
            o.shift = if0.shift_en;
            o.sample = if0.sample_en;
            o.busy = if0.busy;
            o.ecnt = if0.edge_cnt;
        end else begin
            o.sclk = if1.sclk;
            o.shift = if1.shift_en;
            o.sample = if1.sample_en;
            o.busy = if1.busy;
            o.ecnt = if1.edge_cnt;
        end
        return o;
    endfunction

    task automatic cmp(input int d, input exp_t e, input string tag);
        exp_t o;
        o = get_obs(d);
        chk($sformatf("%s.d%0d.sclk", tag, d), 32'(o.sclk), 32'(e.sclk));
        chk($sformatf("%s.d%0d.shift", tag, d), 32'(o.shift), 32'(e.shift));
        chk($sformatf("%s.d%0d.sample", tag, d), 32'(o.sample), 32'(e.sample));
        chk($sformatf("%s.d%0d.busy", tag, d), 32'(o.busy), 32'(e.busy));
        chk($sformatf("%s.d%0d.ecnt", tag, d), 32'(o.ecnt), 32'(e.ecnt));
        chk($sformatf("%s.d%0d.ovl", tag, d), 32'(o.shift & o.sample), 32'd0);
    endtask

    task automatic run(input int ncyc, input string tag);
        for (int i = 0; i < ncyc; i++) begin
            step();
            cmp(0, q0.pop_front(), tag);
            cmp(1, q1.pop_front(), tag);
        end
    endtask

    initial begin
        int shifts;
        int samples;
        int late;
        vectors = 0;
        miscompares = 0;
        rst = 1'b1;
        load = 1'b0;
        if0.clk_cnt_en = 1'b0;
        if1.clk_cnt_en = 1'b0;
        repeat (3) step();

        q0.push_back(idle_exp(1'b0));
        q1.push_back(idle_exp(1'b1));
        run(1, "reset");
        rst = 1'b0;

        // long burst on both configurations, 16+ SCLK periods
        if0.clk_cnt_en = 1'b1;
        if1.clk_cnt_en = 1'b1;
        for (int n = 1; n <= 138; n++) begin
            q0.push_back(run_exp(n, 1'b0, 1'b0));
            q1.push_back(run_exp(n, 1'b1, 1'b1));
        end
        run(138, "burst");

        // reset while dut0 has sclk high in RUN, request left high
        rst = 1'b1;
        q0.push_back(idle_exp(1'b0));
        q1.push_back(idle_exp(1'b1));
        run(1, "midrst");
        rst = 1'b0;

        // fresh burst, then request dropped one clock after the lead edge
        for (int n = 1; n <= 15; n++) begin
            q0.push_back(drop_exp(n, 1'b0, 1'b0));
            q1.push_back(drop_exp(n, 1'b1, 1'b1));
        end
        run(8, "restart");
        if0.clk_cnt_en = 1'b0;
        if1.clk_cnt_en = 1'b0;
        run(7, "drop");

        // single-cycle request aborts in SETUP
        if0.clk_cnt_en = 1'b1;
        if1.clk_cnt_en = 1'b1;
        for (int n = 1; n <= 6; n++) begin
            q0.push_back(pulse_exp(n, 1'b0));
            q1.push_back(pulse_exp(n, 1'b1));
        end
        run(1, "pulse");
        if0.clk_cnt_en = 1'b0;
        if1.clk_cnt_en = 1'b0;
        run(5, "pulse");

        // eight-bit burst with the shifter loaded with 0xA5
        load = 1'b1;
        step();
        load = 1'b0;
        for (int b = 7; b >= 0; b--) begin
            bitq.push_back(((8'hA5 >> b) & 8'h01) != 0);
        end
        shifts = 0;
        samples = 0;
        if0.clk_cnt_en = 1'b1;
        for (int i = 0; i < 200 && shifts < 8; i++) begin
            step();
            if (if0.sample_en) begin
                samples++;
                if (bitq.size() > 0) begin
                    chk($sformatf("mosi%0d", samples), 32'(sr[7]),
                        32'(bitq.pop_front()));
                end
            end
            if (if0.shift_en) begin
                shifts++;
                if (shifts == 8) if0.clk_cnt_en = 1'b0;
            end
        end
        if0.clk_cnt_en = 1'b0;
        chk("shift_cnt", 32'(shifts), 32'd8);
        chk("sample_cnt", 32'(samples), 32'd8);
        chk("bits_left", 32'(bitq.size()), 32'd0);
        late = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            late += int'(if0.shift_en) + int'(if0.sample_en);
        end
        chk("late_strobe", 32'(late), 32'd0);
        chk("end_busy", 32'(if0.busy), 32'd0);
        chk("end_sclk", 32'(if0.sclk), 32'd0);
        chk("end_ecnt", 32'(if0.edge_cnt), 32'd8);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end
endmodule
